// File: rtl/sudoku_board_engine.sv
// 4x4 Sudoku board store with locked givens, cell writes and a sequential row/column/box checker.
// Latency: flag actions take effect one clka edge after the rising flag; a full check takes 48 cycles plus one done cycle.
// Backpressure: none; writes during a check are refused with write_reject, check requests while busy are ignored.
module sudoku_board_engine #(
    parameter logic [47:0] INIT_BOARD = 48'h098602060801,
    parameter int          SCAN_LEN   = 48
) (
    input  logic       clka,
    input  logic       restart,
    input  logic       set_board_flag,
    input  logic       cell_flag,
    input  logic       val_flag,
    input  logic       check_flag,
    input  logic [3:0] data_in,
    input  logic [3:0] rd_addr,
    output logic [2:0] rd_data,
    output logic       busy,
    output logic       check_done,
    output logic       solved,
    output logic       write_reject
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [3:0]  flag_q;
    logic [2:0]  board_q [16];
    logic [2:0]  board_d [16];
    logic [15:0] lock_q, lock_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic        fail_q, fail_d;
    logic        solved_q, solved_d;
    logic        rej_q, rej_d;

    logic        set_e, val_e, cell_e, chk_e;
    logic [3:0]  grp;
    logic [1:0]  pos;
    logic [3:0]  scan_idx;
    logic [2:0]  scan_val;
    logic [3:0]  onehot;
    logic [3:0]  mask_acc;
    logic        grp_fail;
    logic        last;
    logic        wr_ok;

    // Rising-edge detection with fixed priority: set_board > val > cell > check.
    always_comb begin
        set_e  = set_board_flag & ~flag_q[3];
        val_e  = val_flag       & ~flag_q[2] & ~set_e;
        cell_e = cell_flag      & ~flag_q[1] & ~set_e & ~val_e;
        chk_e  = check_flag     & ~flag_q[0] & ~set_e & ~val_e & ~cell_e;
    end

    // Map the scan counter to a cell: groups 0-3 rows, 4-7 columns, 8-11 boxes TL/TR/BL/BR.
    always_comb begin
        grp = cnt_q[5:2];
        pos = cnt_q[1:0];
        case (grp[3:2])
            2'b00:   scan_idx = {grp[1:0], pos};
            2'b01:   scan_idx = {pos, grp[1:0]};
            default: scan_idx = {grp[1], pos[1], grp[0], pos[0]};
        endcase
        scan_val = board_q[scan_idx];
        case (scan_val)
            3'd1:    onehot = 4'b0001;
            3'd2:    onehot = 4'b0010;
            3'd3:    onehot = 4'b0100;
            3'd4:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        // An empty cell contributes no bit, so a group with any 0 can never reach a full mask.
        mask_acc = ((pos == 2'd0) ? 4'b0000 : mask_q) | onehot;
        grp_fail = (pos == 2'd3) && (mask_acc != 4'b1111);
        last     = (cnt_q == 6'(SCAN_LEN - 1));
        wr_ok    = !lock_q[idx_q] && (data_in[2:0] <= 3'd4) && (state_q == S_IDLE);
    end

    // Next-state: flag actions first, then the scan FSM advances unless set_board aborts it.
    always_comb begin
        board_d  = board_q;
        lock_d   = lock_q;
        idx_d    = idx_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        fail_d   = fail_q;
        solved_d = solved_q;
        rej_d    = 1'b0;

        if (set_e) begin
            for (int i = 0; i < 16; i++) begin
                board_d[i] = INIT_BOARD[3*i +: 3];
                lock_d[i]  = |INIT_BOARD[3*i +: 3];
            end
            solved_d = 1'b0;
            state_d  = S_IDLE;
        end else if (val_e) begin
            if (wr_ok) begin
                board_d[idx_q] = data_in[2:0];
                solved_d       = 1'b0;
            end else begin
                rej_d = 1'b1;
            end
        end else if (cell_e) begin
            idx_d = data_in;
        end else if (chk_e && (state_q == S_IDLE)) begin
            state_d = S_SCAN;
            cnt_d   = '0;
            fail_d  = 1'b0;
        end

        if (!set_e) begin
            case (state_q)
                S_SCAN: begin
                    mask_d = mask_acc;
                    fail_d = fail_q | grp_fail;
                    cnt_d  = 6'(cnt_q + 6'd1);
                    if (last) begin
                        state_d  = S_DONE;
                        solved_d = !(fail_q | grp_fail);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    // State registers; restart clears everything, aborting any scan in progress.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            flag_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                board_q[i] <= '0;
            end
            lock_q   <= '0;
            idx_q    <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            fail_q   <= 1'b0;
            solved_q <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            flag_q   <= {set_board_flag, val_flag, cell_flag, check_flag};
            board_q  <= board_d;
            lock_q   <= lock_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            fail_q   <= fail_d;
            solved_q <= solved_d;
            rej_q    <= rej_d;
        end
    end

    // Outputs come straight from state; DONE lasts exactly one cycle so check_done is a pulse.
    always_comb begin
        rd_data      = board_q[rd_addr];
        busy         = (state_q == S_SCAN);
        check_done   = (state_q == S_DONE);
        solved       = solved_q;
        write_reject = rej_q;
    end

endmodule

// File: tb/tb_sudoku_board_engine.sv
// Self-checking bench for sudoku_board_engine: directed stimulus with a scoreboard monitor.
// Latency: write_reject checked one cycle after each val edge, solved checked on each check_done.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_sudoku_board_engine;

    logic       clka = 1'b0;
    logic       restart = 1'b1;
    logic       set_board_flag = 1'b0;
    logic       cell_flag = 1'b0;
    logic       val_flag = 1'b0;
    logic       check_flag = 1'b0;
    logic [3:0] data_in = '0;
    logic [3:0] rd_addr = '0;
    logic [2:0] rd_data;
    logic       busy, check_done, solved, write_reject;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    int wr_q[$];
    int chk_q[$];

    int givens[16] = '{1,0,0,4, 0,4,1,0, 2,0,0,3, 0,3,2,0};
    int sol[16]    = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};

    sudoku_board_engine dut (
        .clka           (clka),
        .restart        (restart),
        .set_board_flag (set_board_flag),
        .cell_flag      (cell_flag),
        .val_flag       (val_flag),
        .check_flag     (check_flag),
        .data_in        (data_in),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .busy           (busy),
        .check_done     (check_done),
        .solved         (solved),
        .write_reject   (write_reject)
    );

    always #5 clka = ~clka;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents write_reject or check_done.
    int  busy_run = 0;
    bit  wr_pend = 0;
    bit  val_prev = 0;
    always @(negedge clka) begin
        if (wr_pend) begin
            if (wr_q.size() == 0) begin
                chk("wr_queue_empty", 1, 0);
            end else begin
                chk("write_reject", int'(write_reject), wr_q.pop_front());
            end
        end else if (write_reject) begin
            chk("spurious_write_reject", 1, 0);
        end
        wr_pend  = val_flag & ~val_prev;
        val_prev = val_flag;

        if (check_done) begin
            done_cnt++;
            if (chk_q.size() == 0) begin
                chk("spurious_check_done", 1, 0);
            end else begin
                chk("solved_on_done", int'(solved), chk_q.pop_front());
                chk("busy_cycles", busy_run, 48);
            end
        end
        if (busy) busy_run++;
        else      busy_run = 0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clka);
        #1;
    endtask

    task automatic do_set();
        set_board_flag = 1'b1; tick(1);
        set_board_flag = 1'b0; tick(1);
    endtask

    task automatic do_cell(input int idx);
        data_in = 4'(idx); cell_flag = 1'b1; tick(1);
        cell_flag = 1'b0; tick(1);
    endtask

    task automatic do_val(input int v, input int exp_rej);
        wr_q.push_back(exp_rej);
        data_in = 4'(v); val_flag = 1'b1; tick(1);
        val_flag = 1'b0; tick(1);
    endtask

    task automatic do_write(input int idx, input int v, input int exp_rej);
        do_cell(idx);
        do_val(v, exp_rej);
    endtask

    task automatic wait_done(input int old);
        int budget;
        budget = 70;
        while (done_cnt == old && budget > 0) begin
            tick(1);
            budget--;
        end
        if (done_cnt == old) chk("check_done_timeout", 0, 1);
    endtask

    task automatic do_check(input int exp_solved, input int hold);
        int old;
        old = done_cnt;
        chk_q.push_back(exp_solved);
        check_flag = 1'b1; tick(hold);
        check_flag = 1'b0; tick(1);
        wait_done(old);
        tick(2);
    endtask

    task automatic probe(input string name, input int addr, input int exp);
        rd_addr = 4'(addr);
        #1;
        chk(name, int'(rd_data), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int old;
        // 1. Reset state
        tick(2);
        chk("reset_busy", int'(busy), 0);
        chk("reset_solved", int'(solved), 0);
        chk("reset_check_done", int'(check_done), 0);
        restart = 1'b0;
        tick(1);
        for (int i = 0; i < 16; i++) probe("reset_rd", i, 0);

        // 2. Load puzzle, check incomplete board
        tick(1);
        do_set();
        probe("given_0", 0, givens[0]);
        probe("given_1", 1, givens[1]);
        probe("given_3", 3, givens[3]);
        tick(1);
        do_check(0, 1);

        // 3. Fill the blanks, check solved; check flag held high acts once
        do_write(1, 2, 0);  do_write(2, 3, 0);  do_write(4, 3, 0);  do_write(7, 2, 0);
        do_write(9, 1, 0);  do_write(10, 4, 0); do_write(12, 4, 0); do_write(15, 1, 0);
        for (int i = 0; i < 16; i++) probe("filled_rd", i, sol[i]);
        tick(1);
        do_check(1, 55);
        tick(5);
        chk("solved_holds", int'(solved), 1);

        // 4. Rejected writes: locked cell, out-of-range value
        do_write(0, 3, 1);
        probe("locked_unchanged", 0, 1);
        chk("solved_after_reject", int'(solved), 1);
        do_write(1, 5, 1);
        probe("range_unchanged", 1, 2);

        // 5. Swap two cells -> not solved; restore -> solved; rewrite clears solved
        do_write(1, 3, 0);
        chk("solved_cleared_by_write", int'(solved), 0);
        do_write(2, 2, 0);
        tick(1);
        do_check(0, 1);
        do_write(1, 2, 0);
        do_write(2, 3, 0);
        tick(1);
        do_check(1, 1);
        do_cell(1);
        wr_q.push_back(0);
        data_in = 4'd2; val_flag = 1'b1; tick(1);
        chk("solved_clears_immediately", int'(solved), 0);
        val_flag = 1'b0; tick(1);

        // Write attempted during a scan is refused
        old = done_cnt;
        chk_q.push_back(1);
        check_flag = 1'b1; tick(1);
        check_flag = 1'b0; tick(1);
        chk("busy_in_scan", int'(busy), 1);
        do_val(1, 1);
        wait_done(old);
        tick(2);
        probe("scan_write_unchanged", 1, 2);

        // 6. set_board aborts a scan with no check_done
        check_flag = 1'b1; tick(1);
        check_flag = 1'b0; tick(18);
        chk("busy_before_abort", int'(busy), 1);
        set_board_flag = 1'b1; tick(1);
        chk("busy_after_set_abort", int'(busy), 0);
        set_board_flag = 1'b0;
        tick(60);
        chk("solved_after_set", int'(solved), 0);
        probe("reloaded_1", 1, 0);

        // restart mid-scan clears outputs asynchronously
        check_flag = 1'b1; tick(1);
        check_flag = 1'b0; tick(19);
        chk("busy_before_restart", int'(busy), 1);
        restart = 1'b1;
        #2;
        chk("restart_busy", int'(busy), 0);
        chk("restart_check_done", int'(check_done), 0);
        chk("restart_solved", int'(solved), 0);
        chk("restart_write_reject", int'(write_reject), 0);
        probe("restart_rd0", 0, 0);
        tick(2);
        restart = 1'b0;
        tick(60);

        chk("wr_queue_drained", wr_q.size(), 0);
        chk("chk_queue_drained", chk_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
